signal_gen_cfg_master: RTL and testbench
========================================

Name: signal_gen_cfg_master

Overview:
- Command-driven AXI-Lite master that programs the signal generator's register block (s_axil slave) over AXI-Lite.
- Accepts one write or read command at a time through a valid/ready port and runs the matching AXI-Lite transaction.
- Returns read data, the AXI response and a timeout status on a response port.
- Sits between the sequencing/software side and the generator. It is the only driver of the generator's AXI-Lite bus.

Parameters:
- G_ADDR_W, 12, AXIL address width; matches the generator.
- G_DATA_B, 4, AXIL data byte width.
- G_DATA_W, G_DATA_B<<3, AXIL data width.
- G_TMO_W, 16, timeout counter width; timeout after 2^G_TMO_W-1 cycles.

Ports:
- i_clk  in  1  single clock.
- i_resetn  in  1  reset, asynchronous, active-low.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command accepted when valid&ready.
- s_cmd_wr  in  1  1=write, 0=read.
- s_cmd_addr  in  G_ADDR_W  register address.
- s_cmd_data  in  G_DATA_W  write data.
- s_cmd_strb  in  G_DATA_B  write strobes.
- m_rsp_valid  out  1  response valid.
- m_rsp_ready  in  1  response consumer ready.
- m_rsp_data  out  G_DATA_W  read data; 0 for writes.
- m_rsp_resp  out  2  BRESP/RRESP; 2'b00 on timeout.
- m_rsp_tmo  out  1  transaction timed out.
- o_busy  out  1  state != IDLE.
- m_axil_aw{valid,ready,addr,prot}, m_axil_w{valid,ready,data,strb}, m_axil_b{valid,ready,resp}, m_axil_ar{valid,ready,addr,prot}, m_axil_r{valid,ready,data,resp}  standard AXI-Lite master; prot driven 3'b000.

Behaviour:
- Reset (async assert, release sync to i_clk):
  - All valid/ready outputs 0; state IDLE.
  - rsp fields 0; address/data registers 0.
- States and transitions:
  - IDLE: s_cmd_ready=1. On accept, latch addr/data/strb/wr. Go to WR_REQ if wr=1, else RD_REQ.
  - WR_REQ: awvalid and wvalid asserted together next cycle.
    - Each drops independently on its own handshake.
    - Go to WR_RESP when both done. AW and W may finish in the same or different cycles, in either order.
  - WR_RESP: bready=1. On bvalid, latch bresp, go to RSP.
  - RD_REQ: arvalid until arready, then RD_RESP.
  - RD_RESP: rready=1. On rvalid, latch rdata/rresp, go to RSP.
  - RSP: m_rsp_valid=1 with stable fields until m_rsp_ready, then IDLE.
  - DRAIN: see timeout below.
- Valid signals are never withdrawn before handshake, per AXI.
- Timeout:
  - Counter clears on entering WR_RESP/RD_RESP and increments each cycle while waiting there.
  - At all-ones: m_rsp_tmo=1, resp=00, data=0, go to RSP. After RSP the block goes to DRAIN, not IDLE.
  - DRAIN: bready or rready held 1, matching the pending type; s_cmd_ready=0. The late response is absorbed and discarded, then IDLE.
  - No timeout in request phases.
- Minimum latency, zero-wait slave: command accept at cycle 0 → aw/w valid at 1 → bvalid sampled at 2 → m_rsp_valid at 3. Reads follow the same timing.
- Response at the exact timeout cycle: the real response wins; m_rsp_tmo=0.
- One outstanding transaction max; s_cmd_ready=0 outside IDLE.
- m_rsp_ready held high does not shorten RSP below 1 cycle.

Decomposition:
- Shared package signal_gen_pkg holds:
  - state enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN);
  - AXI response constants OKAY/EXOKAY/SLVERR/DECERR;
  - PROT default 3'b000.
- Single module; the timeout counter stays inline. No sub-module warranted.

Test Plan:
- Write 0x004 ← 0x0000_00A5, strb 4'hF; slave awready/wready in the same cycle, bresp 00 → m_rsp_valid at cycle 3, resp 00, tmo 0, data 0.
- Write where the slave takes W 3 cycles before AW → awvalid held until accepted, wvalid drops after its handshake; a single response with resp 00.
- Read 0x008; slave returns 0xDEAD_BEEF with rresp 10 after 5 wait cycles → m_rsp_data 0xDEAD_BEEF, resp 10.
- Read with G_TMO_W=4 and a slave that never responds → m_rsp_tmo=1 after 15 waiting cycles. Then DRAIN holds s_cmd_ready=0 until a late rvalid, after which IDLE.
- Hold m_rsp_ready=0 for 10 cycles → response fields stable; s_cmd_ready=0 throughout.
- Assert i_resetn low mid-WR_REQ → all m_axil valids 0 immediately (async), state IDLE after release.

Source files
------------

// File: rtl/signal_gen_pkg.sv
// Shared definitions for the signal generator configuration path:
// master FSM states, AXI-Lite response codes and the default protection value.
`timescale 1ns/1ps
package signal_gen_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5,
    DRAIN   = 3'd6
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/signal_gen_cfg_master.sv
// Command-driven AXI-Lite master for the signal generator register block.
// One command at a time: latch it, run the AXI-Lite write or read, then
// present the result on the response port. A response that never arrives is
// reported as a timeout, and the late beat is absorbed in DRAIN afterwards.
`timescale 1ns/1ps
module signal_gen_cfg_master
  import signal_gen_pkg::*;
#(
  parameter int G_ADDR_W = 12,
  parameter int G_DATA_B = 4,
  parameter int G_DATA_W = G_DATA_B << 3,
  parameter int G_TMO_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  // command port
  input  logic                s_cmd_valid,
  output logic                s_cmd_ready,
  input  logic                s_cmd_wr,
  input  logic [G_ADDR_W-1:0] s_cmd_addr,
  input  logic [G_DATA_W-1:0] s_cmd_data,
  input  logic [G_DATA_B-1:0] s_cmd_strb,
  // response port
  output logic                m_rsp_valid,
  input  logic                m_rsp_ready,
  output logic [G_DATA_W-1:0] m_rsp_data,
  output logic [1:0]          m_rsp_resp,
  output logic                m_rsp_tmo,
  output logic                o_busy,
  // AXI-Lite write address
  output logic                m_axil_awvalid,
  input  logic                m_axil_awready,
  output logic [G_ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]          m_axil_awprot,
  // AXI-Lite write data
  output logic                m_axil_wvalid,
  input  logic                m_axil_wready,
  output logic [G_DATA_W-1:0] m_axil_wdata,
  output logic [G_DATA_B-1:0] m_axil_wstrb,
  // AXI-Lite write response
  input  logic                m_axil_bvalid,
  output logic                m_axil_bready,
  input  logic [1:0]          m_axil_bresp,
  // AXI-Lite read address
  output logic                m_axil_arvalid,
  input  logic                m_axil_arready,
  output logic [G_ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]          m_axil_arprot,
  // AXI-Lite read data
  input  logic                m_axil_rvalid,
  output logic                m_axil_rready,
  input  logic [G_DATA_W-1:0] m_axil_rdata,
  input  logic [1:0]          m_axil_rresp
);

  localparam logic [G_TMO_W-1:0] TMO_MAX = '1;
  localparam logic [G_TMO_W-1:0] TMO_ONE = G_TMO_W'(1);

  state_e                state_q,   state_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  wr_q,      wr_d;
  logic [G_ADDR_W-1:0]   addr_q,    addr_d;
  logic [G_DATA_W-1:0]   data_q,    data_d;
  logic [G_DATA_B-1:0]   strb_q,    strb_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q,  w_pend_d;
  logic                  ar_pend_q, ar_pend_d;
  logic [G_TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [G_DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_tmo_q,  rsp_tmo_d;

  logic aw_done;
  logic w_done;

  // A request channel is finished once it was never pending or handshakes now.
  assign aw_done = !aw_pend_q || m_axil_awready;
  assign w_done  = !w_pend_q  || m_axil_wready;

  // Next-state and datapath: defaults hold every register, each state
  // overrides only what it owns.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    ar_pend_d  = ar_pend_q;
    tmo_cnt_d  = tmo_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    rsp_tmo_d  = rsp_tmo_q;

    case (state_q)
      IDLE: begin
        if (s_cmd_valid && cmd_rdy_q) begin
          wr_d   = s_cmd_wr;
          addr_d = s_cmd_addr;
          data_d = s_cmd_data;
          strb_d = s_cmd_strb;
          if (s_cmd_wr) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            ar_pend_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // AW and W retire independently; move on once both are gone.
        if (aw_pend_q && m_axil_awready) aw_pend_d = 1'b0;
        if (w_pend_q && m_axil_wready)   w_pend_d  = 1'b0;
        if (aw_done && w_done) begin
          tmo_cnt_d = '0;
          state_d   = WR_RESP;
        end
      end

      WR_RESP: begin
        // A real response in the last counted cycle still beats the timeout.
        if (m_axil_bvalid) begin
          rsp_data_d = '0;
          rsp_resp_d = m_axil_bresp;
          rsp_tmo_d  = 1'b0;
          state_d    = RSP;
        end else if (tmo_cnt_q == TMO_MAX) begin
          rsp_data_d = '0;
          rsp_resp_d = OKAY;
          rsp_tmo_d  = 1'b1;
          state_d    = RSP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end

      RD_REQ: begin
        if (m_axil_arready) begin
          ar_pend_d = 1'b0;
          tmo_cnt_d = '0;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (m_axil_rvalid) begin
          rsp_data_d = m_axil_rdata;
          rsp_resp_d = m_axil_rresp;
          rsp_tmo_d  = 1'b0;
          state_d    = RSP;
        end else if (tmo_cnt_q == TMO_MAX) begin
          rsp_data_d = '0;
          rsp_resp_d = OKAY;
          rsp_tmo_d  = 1'b1;
          state_d    = RSP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
      end

      RSP: begin
        // After a timeout the slave still owes a beat; swallow it before idling.
        if (m_rsp_ready) state_d = rsp_tmo_q ? DRAIN : IDLE;
      end

      DRAIN: begin
        if (wr_q ? m_axil_bvalid : m_axil_rvalid) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Registered so that the command port stays closed during reset and
    // opens on the first clock after release.
    cmd_rdy_d = (state_d == IDLE);
  end

  // State and datapath registers; asynchronous assert, synchronous release.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= IDLE;
      cmd_rdy_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      ar_pend_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= '0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_rdy_q  <= cmd_rdy_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      ar_pend_q  <= ar_pend_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
      rsp_tmo_q  <= rsp_tmo_d;
    end
  end

  assign s_cmd_ready    = cmd_rdy_q;
  assign o_busy         = (state_q != IDLE);

  assign m_rsp_valid    = (state_q == RSP);
  assign m_rsp_data     = rsp_data_q;
  assign m_rsp_resp     = rsp_resp_q;
  assign m_rsp_tmo      = rsp_tmo_q;

  assign m_axil_awvalid = aw_pend_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT_DEFAULT;
  assign m_axil_wvalid  = w_pend_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = strb_q;
  assign m_axil_bready  = (state_q == WR_RESP) || ((state_q == DRAIN) && wr_q);

  assign m_axil_arvalid = ar_pend_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT_DEFAULT;
  assign m_axil_rready  = (state_q == RD_RESP) || ((state_q == DRAIN) && !wr_q);

endmodule

// File: tb/tb_signal_gen_cfg_master.sv
// Bench for signal_gen_cfg_master: directed plus random commands against a
// behavioural AXI-Lite register slave; expected responses are queued at
// issue time and checked by an independent response monitor.
`timescale 1ns/1ps
module tb_signal_gen_cfg_master;
  import signal_gen_pkg::*;

  localparam int AW = 12;
  localparam int DB = 4;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int TMO_LIM = (1 << TW) - 1;  // longest response wait that still wins

  logic          i_clk = 1'b0;
  logic          i_resetn = 1'b0;
  logic          s_cmd_valid = 1'b0, s_cmd_ready, s_cmd_wr = 1'b0;
  logic [AW-1:0] s_cmd_addr = '0;
  logic [DW-1:0] s_cmd_data = '0;
  logic [DB-1:0] s_cmd_strb = '0;
  logic          m_rsp_valid, m_rsp_ready, m_rsp_tmo, o_busy;
  logic [DW-1:0] m_rsp_data;
  logic [1:0]    m_rsp_resp;
  logic          m_axil_awvalid, m_axil_awready = 1'b0;
  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_wvalid, m_axil_wready = 1'b0;
  logic [DW-1:0] m_axil_wdata;
  logic [DB-1:0] m_axil_wstrb;
  logic          m_axil_bvalid = 1'b0, m_axil_bready;
  logic [1:0]    m_axil_bresp = '0;
  logic          m_axil_arvalid, m_axil_arready = 1'b0;
  logic [AW-1:0] m_axil_araddr;
  logic [2:0]    m_axil_arprot;
  logic          m_axil_rvalid = 1'b0, m_axil_rready;
  logic [DW-1:0] m_axil_rdata = '0;
  logic [1:0]    m_axil_rresp = '0;

  signal_gen_cfg_master #(
    .G_ADDR_W(AW), .G_DATA_B(DB), .G_DATA_W(DW), .G_TMO_W(TW)
  ) dut (
    .i_clk(i_clk), .i_resetn(i_resetn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
    .s_cmd_addr(s_cmd_addr), .s_cmd_data(s_cmd_data), .s_cmd_strb(s_cmd_strb),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
    .m_rsp_resp(m_rsp_resp), .m_rsp_tmo(m_rsp_tmo), .o_busy(o_busy),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp)
  );

  initial forever #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;
  bit proto_en = 1'b1;
  bit txn_active = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          tmo;
    bit            chk_lat;
    int            acc_cyc;
    int            hold;
    int            id;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] ref_mem [16];   // what software expects the registers to hold
  logic [DW-1:0] slv_mem [16];   // what the bench slave actually stores

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0: return m_axil_awvalid;
      1: return m_axil_wvalid;
      2: return m_axil_arvalid;
      3: return m_axil_bready;
      4: return m_axil_rready;
      default: return s_cmd_ready;
    endcase
  endfunction

  // Returns #1 after a clock edge at which the selected signal reads 1.
  task automatic wait_hi(input int which, input string name);
    int n = 0;
    while (!sig_of(which) && n < 400) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!sig_of(which)) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: still 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  // Issue one command and play the slave side of the AXI-Lite transaction.
  // rsp_dly = idle cycles the slave waits in the response phase before its beat.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [DB-1:0] strb, input int aw_dly, input int w_dly,
                         input int ar_dly, input int rsp_dly, input logic [1:0] resp,
                         input int hold, input bit chk_lat);
    exp_t e;
    int   idx = int'(addr[5:2]);
    e.tmo = (rsp_dly > TMO_LIM);
    if (wr) begin
      for (int b = 0; b < DB; b++) if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
      e.data = '0;
    end else begin
      e.data = e.tmo ? '0 : ref_mem[idx];
    end
    e.resp = e.tmo ? OKAY : resp;
    e.hold = hold;
    e.chk_lat = chk_lat;
    e.acc_cyc = -100;
    e.id = txn_id++;
    exp_q.push_back(e);

    s_cmd_wr = wr; s_cmd_addr = addr; s_cmd_data = data; s_cmd_strb = strb;
    s_cmd_valid = 1'b1;
    wait_hi(5, "cmd_ready");
    @(posedge i_clk); #1;
    s_cmd_valid = 1'b0;
    exp_q[$].acc_cyc = cyc;
    txn_active = 1'b1;

    if (wr) begin
      fork
        begin
          wait_hi(0, "awvalid");
          cycles(aw_dly);
          chk("awaddr", m_axil_awaddr, addr);
          m_axil_awready = 1'b1;
          @(posedge i_clk); #1;
          m_axil_awready = 1'b0;
          chk("awvalid_drop", m_axil_awvalid, 1'b0);
        end
        begin
          wait_hi(1, "wvalid");
          cycles(w_dly);
          chk("wdata", m_axil_wdata, data);
          chk("wstrb", m_axil_wstrb, strb);
          for (int b = 0; b < DB; b++)
            if (m_axil_wstrb[b]) slv_mem[int'(m_axil_awaddr[5:2])][8*b +: 8] = m_axil_wdata[8*b +: 8];
          m_axil_wready = 1'b1;
          @(posedge i_clk); #1;
          m_axil_wready = 1'b0;
          chk("wvalid_drop", m_axil_wvalid, 1'b0);
        end
      join
      cycles(rsp_dly);
      m_axil_bvalid = 1'b1;
      m_axil_bresp  = resp;
      wait_hi(3, "bready");
      @(posedge i_clk); #1;
      m_axil_bvalid = 1'b0;
    end else begin
      wait_hi(2, "arvalid");
      cycles(ar_dly);
      chk("araddr", m_axil_araddr, addr);
      idx = int'(m_axil_araddr[5:2]);
      m_axil_arready = 1'b1;
      @(posedge i_clk); #1;
      m_axil_arready = 1'b0;
      chk("arvalid_drop", m_axil_arvalid, 1'b0);
      cycles(rsp_dly);
      m_axil_rvalid = 1'b1;
      m_axil_rdata  = slv_mem[idx];
      m_axil_rresp  = resp;
      wait_hi(4, "rready");
      @(posedge i_clk); #1;
      m_axil_rvalid = 1'b0;
    end
    txn_active = 1'b0;
    // A timed-out transaction ends in DRAIN; absorbing the late beat reopens the port.
    if (e.tmo) chk("drain_to_idle", s_cmd_ready, 1'b1);
  endtask

  // Response monitor: snapshot at first valid, require stability while
  // stalled, compare against the queued expectation at the handshake.
  initial begin
    bit            vld_prev = 1'b0, rdy_prev = 1'b0, in_rsp = 1'b0;
    int            hold_cnt = 0;
    logic [DW-1:0] s_data;
    logic [1:0]    s_resp;
    logic          s_tmo;
    exp_t          e;
    m_rsp_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (vld_prev && rdy_prev) begin
        in_rsp = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got response data=0x%0h, required none", s_data);
        end else begin
          e = exp_q.pop_front();
          $display("rsp %0d: data=0x%08h resp=%b tmo=%b (exp 0x%08h %b %b)",
                   e.id, s_data, s_resp, s_tmo, e.data, e.resp, e.tmo);
          chk($sformatf("rsp%0d_data", e.id), s_data, e.data);
          chk($sformatf("rsp%0d_resp", e.id), s_resp, e.resp);
          chk($sformatf("rsp%0d_tmo", e.id), s_tmo, e.tmo);
        end
      end
      if (m_rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          s_data = m_rsp_data; s_resp = m_rsp_resp; s_tmo = m_rsp_tmo;
          hold_cnt = (exp_q.size() != 0) ? exp_q[0].hold : 0;
          if (exp_q.size() != 0 && exp_q[0].chk_lat)
            chk("rsp_latency", cyc, exp_q[0].acc_cyc + 2);
        end else begin
          chk("rsp_stable_data", m_rsp_data, s_data);
          chk("rsp_stable_resp", m_rsp_resp, s_resp);
          chk("rsp_stable_tmo", m_rsp_tmo, s_tmo);
          chk("cmd_ready_in_rsp", s_cmd_ready, 1'b0);
        end
        m_rsp_ready = (hold_cnt == 0);
        if (hold_cnt > 0) hold_cnt--;
      end else begin
        m_rsp_ready = 1'b0;
      end
      vld_prev = m_rsp_valid;
      rdy_prev = m_rsp_ready;
    end
  end

  // AXI request-channel rule: valid and payload stay put until accepted.
  // Also the command port must stay closed while a transaction is in flight.
  initial begin
    logic          pa_v = 0, pa_r = 0, pw_v = 0, pw_r = 0, pr_v = 0, pr_r = 0;
    logic [AW-1:0] pa_a = '0, pr_a = '0;
    logic [DW-1:0] pw_d = '0;
    forever begin
      @(negedge i_clk);
      if (proto_en) begin
        if (pa_v && !pa_r) chk("awvalid_held", {m_axil_awvalid, m_axil_awaddr}, {1'b1, pa_a});
        if (pw_v && !pw_r) chk("wvalid_held", {m_axil_wvalid, m_axil_wdata}, {1'b1, pw_d});
        if (pr_v && !pr_r) chk("arvalid_held", {m_axil_arvalid, m_axil_araddr}, {1'b1, pr_a});
        if (txn_active) chk("cmd_ready_busy", s_cmd_ready, 1'b0);
      end
      pa_v = m_axil_awvalid; pa_r = m_axil_awready; pa_a = m_axil_awaddr;
      pw_v = m_axil_wvalid;  pw_r = m_axil_wready;  pw_d = m_axil_wdata;
      pr_v = m_axil_arvalid; pr_r = m_axil_arready; pr_a = m_axil_araddr;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end

    // Reset state
    cycles(3);
    chk("rst_cmd_ready", s_cmd_ready, 1'b0);
    chk("rst_rsp_valid", m_rsp_valid, 1'b0);
    chk("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid}, 3'b000);
    chk("rst_readys", {m_axil_bready, m_axil_rready}, 2'b00);
    chk("rst_rsp_fields", {m_rsp_data, m_rsp_resp, m_rsp_tmo}, '0);
    chk("rst_addr", {m_axil_awaddr, m_axil_wdata, m_axil_wstrb}, '0);
    chk("rst_prot", {m_axil_awprot, m_axil_arprot}, 6'b0);
    chk("rst_busy", o_busy, 1'b0);
    i_resetn = 1'b1;
    cycles(1);
    chk("post_rst_cmd_ready", s_cmd_ready, 1'b1);

    // Zero-wait write: response sampled 3 edges after accept
    run_txn(1, 12'h004, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, OKAY, 0, 1);
    // W accepted 3 cycles before AW
    run_txn(1, 12'h00C, 32'h1234_5678, 4'hF, 3, 0, 0, 1, OKAY, 0, 0);
    // Read with wait states and SLVERR
    run_txn(1, 12'h008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, OKAY, 0, 0);
    run_txn(0, 12'h008, '0, '0, 0, 0, 0, 5, SLVERR, 0, 0);
    // Zero-wait read latency
    run_txn(0, 12'h004, '0, '0, 0, 0, 0, 0, OKAY, 0, 1);
    // Timeout boundary: last counted cycle wins, one later times out
    run_txn(0, 12'h00C, '0, '0, 0, 0, 0, TMO_LIM, DECERR, 0, 0);
    run_txn(1, 12'h010, 32'hCAFE_F00D, 4'h5, 1, 2, 0, TMO_LIM + 1, SLVERR, 0, 0);
    // Slave that answers only long after the timeout: DRAIN absorbs it
    run_txn(0, 12'h008, '0, '0, 1, 0, 2, TMO_LIM + 6, SLVERR, 3, 0);
    // Response consumer stalls for 10 cycles
    run_txn(0, 12'h010, '0, '0, 0, 0, 1, 2, EXOKAY, 10, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int dly;
      dly = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO_LIM - 1, TMO_LIM + 2)
                                        : $urandom_range(0, 5);
      run_txn($urandom_range(0, 1), 12'({$urandom_range(0, 15), 2'b00}), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), dly, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin cycles(1); n++; end
    chk("rsp_queue_drained", exp_q.size(), 0);
    cycles(2);

    // Asynchronous reset in the middle of a write request
    proto_en = 1'b0;
    s_cmd_wr = 1'b1; s_cmd_addr = 12'h014; s_cmd_data = 32'h5555_AAAA; s_cmd_strb = 4'hF;
    s_cmd_valid = 1'b1;
    wait_hi(5, "cmd_ready_rst");
    @(posedge i_clk); #1;
    s_cmd_valid = 1'b0;
    cycles(1);
    chk("wr_req_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
    #2 i_resetn = 1'b0;
    #1;
    chk("async_rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_rsp_valid}, 4'b0000);
    chk("async_rst_busy", o_busy, 1'b0);
    chk("async_rst_cmd_ready", s_cmd_ready, 1'b0);
    cycles(2);
    i_resetn = 1'b1;
    cycles(2);
    chk("rst_release_idle", {s_cmd_ready, o_busy}, 2'b10);
    proto_en = 1'b1;

    // Registers survive a normal read after the reset sequence
    run_txn(0, 12'h004, '0, '0, 0, 0, 0, 0, OKAY, 0, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin cycles(1); n++; end
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
